// File: rtl/fifo_stream_rd_pkg.sv
// Shared types and helpers for the FIFO drain controller and its output buffer.
package fifo_stream_pkg;

  typedef logic [31:0] stat_cnt_t;
  localparam stat_cnt_t STAT_CNT_MAX = 32'hFFFF_FFFF;

  // Pointer width for a circular buffer; never less than one bit.
  function automatic int clog2_min1(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_stream_rd_if.sv
// FIFO read port plus valid/ready stream output, bundled for the drain controller.
// Optional stats counters exist only when FIFO_STREAM_RD_STATS_EN is defined.
interface fifo_stream_rd_if #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_BUF_DEPTH  = 3
);
  import fifo_stream_pkg::*;

  logic                               i_fifo_empty;
  logic [P_DATA_WIDTH-1:0]            i_fifo_data;
  logic                               o_fifo_rd_en;
  logic                               i_flush;
  logic                               o_valid;
  logic [P_DATA_WIDTH-1:0]            o_data;
  logic                               i_ready;
  logic [$clog2(P_BUF_DEPTH+1)-1:0]   o_level;
`ifdef FIFO_STREAM_RD_STATS_EN
  stat_cnt_t                          o_stall_cnt;
  stat_cnt_t                          o_starve_cnt;
`endif

  modport master (
    input  i_fifo_empty, i_fifo_data, i_flush, i_ready,
    output o_fifo_rd_en, o_valid, o_data, o_level
`ifdef FIFO_STREAM_RD_STATS_EN
    , output o_stall_cnt, o_starve_cnt
`endif
  );

  modport slave (
    output i_fifo_empty, i_fifo_data, i_flush, i_ready,
    input  o_fifo_rd_en, o_valid, o_data, o_level
`ifdef FIFO_STREAM_RD_STATS_EN
    , input o_stall_cnt, o_starve_cnt
`endif
  );

endinterface

// File: rtl/fifo_stream_rd_stream_obuf.sv
// Circular output buffer of P_BUF_DEPTH words; non-power-of-2 depths wrap explicitly.
// Write and pop may coincide; flush empties it at the end of the cycle.
module stream_obuf
  import fifo_stream_pkg::*;
#(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_BUF_DEPTH  = 3
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_wr_en,
  input  logic [P_DATA_WIDTH-1:0]            i_wr_data,
  input  logic                               i_pop,
  input  logic                               i_flush,
  output logic [$clog2(P_BUF_DEPTH+1)-1:0]   o_occ,
  output logic [P_DATA_WIDTH-1:0]            o_head
);

  localparam int PW = clog2_min1(P_BUF_DEPTH);
  localparam int LW = $clog2(P_BUF_DEPTH + 1);

  logic [P_DATA_WIDTH-1:0] mem [P_BUF_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [LW-1:0]           occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(P_BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < P_BUF_DEPTH; i++) mem[i] <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (i_wr_en) begin
        mem[wr_ptr] <= i_wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (i_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (i_wr_en && !i_pop)      occ <= occ + LW'(1);
      else if (!i_wr_en && i_pop) occ <= occ - LW'(1);
    end
  end

  assign o_occ  = occ;
  assign o_head = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_rd.sv
// Drain-side FIFO controller: pops ahead into stream_obuf so i_ready never reaches o_fifo_rd_en.
// Define FIFO_STREAM_RD_STATS_EN to add saturating stall/starve counters.
module fifo_stream_rd
  import fifo_stream_pkg::*;
#(
  parameter int P_DATA_WIDTH   = 32,
  parameter bit P_FALL_THROUGH = 1'b0,
  parameter int P_BUF_DEPTH    = 3
) (
  input  logic           i_clk,
  input  logic           i_rst,
  fifo_stream_rd_if.master bus
);

  localparam int LW = $clog2(P_BUF_DEPTH + 1);

  logic          inflight;
  logic [LW-1:0] occ;
  logic          rd_en;
  logic          wr_en;
  logic          xfer;
  logic [LW:0]   committed;

  // Words already owned by the buffer, counting one still on the FIFO read bus.
  assign committed = {1'b0, occ} + {{LW{1'b0}}, inflight};
  assign rd_en = !i_rst && !bus.i_fifo_empty && !bus.i_flush &&
                 (committed < (LW+1)'(P_BUF_DEPTH));
  assign xfer  = bus.o_valid && bus.i_ready;

  generate
    if (P_FALL_THROUGH) begin : g_fall_through
      assign inflight = 1'b0;
      assign wr_en    = rd_en;
    end else begin : g_registered
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) inflight <= 1'b0;
        else       inflight <= rd_en;
      end
      // A flush in the arrival cycle drops the word on the read bus.
      assign wr_en = inflight && !bus.i_flush;
    end
  endgenerate

  stream_obuf #(
    .P_DATA_WIDTH (P_DATA_WIDTH),
    .P_BUF_DEPTH  (P_BUF_DEPTH)
  ) u_obuf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (wr_en),
    .i_wr_data (bus.i_fifo_data),
    .i_pop     (xfer),
    .i_flush   (bus.i_flush),
    .o_occ     (occ),
    .o_head    (bus.o_data)
  );

  assign bus.o_fifo_rd_en = rd_en;
  assign bus.o_valid      = (occ != '0);
  assign bus.o_level      = occ;

`ifdef FIFO_STREAM_RD_STATS_EN
  stat_cnt_t stall_cnt;
  stat_cnt_t starve_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt  <= '0;
      starve_cnt <= '0;
    end else if (bus.i_flush) begin
      stall_cnt  <= '0;
      starve_cnt <= '0;
    end else begin
      if (bus.o_valid && !bus.i_ready && stall_cnt != STAT_CNT_MAX)
        stall_cnt <= stall_cnt + 32'd1;
      if (!bus.o_valid && bus.i_ready && bus.i_fifo_empty && starve_cnt != STAT_CNT_MAX)
        starve_cnt <= starve_cnt + 32'd1;
    end
  end

  assign bus.o_stall_cnt  = stall_cnt;
  assign bus.o_starve_cnt = starve_cnt;
`endif

endmodule

// File: tb/tb_fifo_stream_rd.sv
// Bench for fifo_stream_rd: registered-read and fall-through instances against a queue model.
module tb_fifo_stream_rd;
  import fifo_stream_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_stream_rd_if #(.P_DATA_WIDTH(DW), .P_BUF_DEPTH(DEPTH)) bus0 ();
  fifo_stream_rd_if #(.P_DATA_WIDTH(DW), .P_BUF_DEPTH(DEPTH)) bus1 ();

  fifo_stream_rd #(.P_DATA_WIDTH(DW), .P_FALL_THROUGH(1'b0), .P_BUF_DEPTH(DEPTH))
    u_reg (.i_clk(clk), .i_rst(rst), .bus(bus0));
  fifo_stream_rd #(.P_DATA_WIDTH(DW), .P_FALL_THROUGH(1'b1), .P_BUF_DEPTH(DEPTH))
    u_ft  (.i_clk(clk), .i_rst(rst), .bus(bus1));

  int vectors = 0;
  int errors  = 0;

  int          ft = 0;          // which instance is active
  logic [31:0] src  [$];        // words sitting in the source FIFO
  logic [31:0] obuf [$];        // words the DUT must currently be holding
  logic [31:0] fly  [$];        // popped, not yet captured (registered FIFO)
  logic [31:0] fdat = '0;       // registered FIFO read-data bus
  logic        tb_ready = 1'b0;
  logic        tb_flush = 1'b0;

  logic        s_v, s_re;
  logic [31:0] s_d;
  int          s_l;
  logic [31:0] got [16];
  int          nv;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    logic        emp;
    logic [31:0] d;
    emp = (src.size() == 0);
    d   = (ft != 0) ? (emp ? 32'h0 : src[0]) : fdat;
    bus0.i_fifo_empty = (ft == 0) ? emp : 1'b1;
    bus0.i_fifo_data  = (ft == 0) ? d : 32'h0;
    bus0.i_flush      = (ft == 0) && tb_flush;
    bus0.i_ready      = (ft == 0) && tb_ready;
    bus1.i_fifo_empty = (ft == 1) ? emp : 1'b1;
    bus1.i_fifo_data  = (ft == 1) ? d : 32'h0;
    bus1.i_flush      = (ft == 1) && tb_flush;
    bus1.i_ready      = (ft == 1) && tb_ready;
  endtask

  // One clock: sample and check mid-cycle, then advance the model past the edge.
  task automatic step();
    logic        exp_re, exp_v, xfer;
    logic [31:0] w;
    drive();
    @(negedge clk);
    if (ft == 0) begin
      s_v = bus0.o_valid; s_d = bus0.o_data; s_re = bus0.o_fifo_rd_en; s_l = int'(bus0.o_level);
    end else begin
      s_v = bus1.o_valid; s_d = bus1.o_data; s_re = bus1.o_fifo_rd_en; s_l = int'(bus1.o_level);
    end
    exp_re = (src.size() != 0) && !tb_flush && ((obuf.size() + fly.size()) < DEPTH);
    exp_v  = (obuf.size() != 0);
    cmp("rd_en", s_re, exp_re);
    cmp("valid", s_v, exp_v);
    cmp("level", s_l, obuf.size());
    if (exp_v) cmp("data", s_d, obuf[0]);
    if (s_l > DEPTH) begin
      errors++;
      $display("FAIL occ_bound: got %0d limit %0d at %0t", s_l, DEPTH, $time);
    end
    xfer = exp_v && tb_ready;
    @(posedge clk);
    #1;
    if (tb_flush) begin
      obuf.delete();
      fly.delete();
    end else begin
      if (xfer) void'(obuf.pop_front());
      if (fly.size() != 0) obuf.push_back(fly.pop_front());
      if (exp_re) begin
        w = src.pop_front();
        if (ft != 0) obuf.push_back(w);
        else begin
          fly.push_back(w);
          fdat = w;
        end
      end
    end
  endtask

  task automatic collect(input int cycles);
    nv = 0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (s_v && tb_ready) begin
        if (nv < 16) got[nv] = s_d;
        nv++;
      end
    end
  endtask

  task automatic rand_phase(input int n, input int ready_pct);
    for (int c = 0; c < n; c++) begin
      tb_ready = ($urandom_range(0, 99) < ready_pct);
      tb_flush = ($urandom_range(0, 24) == 0);
      if (src.size() < 12 && $urandom_range(0, 1) == 1) src.push_back($urandom);
      step();
    end
    tb_flush = 1'b0;
  endtask

  task automatic drain();
    tb_ready = 1'b1;
    tb_flush = 1'b0;
    for (int c = 0; c < 64 && (src.size() + obuf.size() + fly.size()) != 0; c++) step();
    cmp("drain_done", src.size() + obuf.size() + fly.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_pop, first_v, last_v, npop;
    rst = 1'b1;
    drive();
    #2;
    cmp("rst_valid", bus0.o_valid, 1'b0);
    cmp("rst_data",  bus0.o_data, 32'h0);
    cmp("rst_level", bus0.o_level, 0);
    cmp("rst_rd_en", bus0.o_fifo_rd_en, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Streaming at full rate.
    for (int k = 0; k < 8; k++) src.push_back(32'h10 + k);
    tb_ready = 1'b1;
    first_pop = -1; first_v = -1; last_v = -1; nv = 0;
    for (int c = 0; c < 14; c++) begin
      step();
      if (s_re && first_pop < 0) first_pop = c;
      if (s_v) begin
        if (first_v < 0) first_v = c;
        if (nv < 16) got[nv] = s_d;
        last_v = c;
        nv++;
      end
    end
    cmp("stream_first_pop", first_pop, 0);
    cmp("stream_pop_to_valid", first_v - first_pop, 2);
    cmp("stream_count", nv, 8);
    cmp("stream_span", last_v - first_v, 7);
    for (int k = 0; k < 8; k++) cmp("stream_data", got[k], 32'h10 + k);

    // Backpressure: exactly DEPTH pops, head held.
    tb_ready = 1'b0;
    for (int k = 0; k < 8; k++) src.push_back(32'h20 + k);
    npop = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (s_re) npop++;
    end
    cmp("bp_pops", npop, 3);
    cmp("bp_level", s_l, 3);
    cmp("bp_head", s_d, 32'h20);
    tb_ready = 1'b1;
    collect(16);
    cmp("bp_count", nv, 8);
    for (int k = 0; k < 8; k++) cmp("bp_data", got[k], 32'h20 + k);

    // Flush with two buffered and one in flight.
    tb_ready = 1'b0;
    for (int k = 0; k < 6; k++) src.push_back(32'h30 + k);
    for (int c = 0; c < 3; c++) step();
    tb_flush = 1'b1;
    step();
    cmp("flush_pre_level", s_l, 2);
    tb_flush = 1'b0;
    step();
    cmp("flush_valid", s_v, 1'b0);
    cmp("flush_level", s_l, 0);
    tb_ready = 1'b1;
    collect(12);
    cmp("flush_count", nv, 3);
    for (int k = 0; k < 3; k++) cmp("flush_data", got[k], 32'h33 + k);

    // Asynchronous reset between edges while streaming.
    for (int k = 0; k < 8; k++) src.push_back(32'h40 + k);
    for (int c = 0; c < 4; c++) step();
    #2 rst = 1'b1;
    #1;
    cmp("arst_valid", bus0.o_valid, 1'b0);
    cmp("arst_rd_en", bus0.o_fifo_rd_en, 1'b0);
    cmp("arst_level", bus0.o_level, 0);
    obuf.delete();
    fly.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    collect(12);
    cmp("arst_count", nv, 4);
    cmp("arst_resume", got[0], 32'h44);

    rand_phase(300, 75);
    rand_phase(200, 20);
    drain();

`ifdef FIFO_STREAM_RD_STATS_EN
    tb_flush = 1'b1;
    step();
    tb_flush = 1'b0;
    tb_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    tb_ready = 1'b0;
    src.push_back(32'h55);
    for (int c = 0; c < 7; c++) step();
    cmp("stats_stall", bus0.o_stall_cnt, 32'd5);
    cmp("stats_starve", bus0.o_starve_cnt, 32'd4);
    force u_reg.stall_cnt  = 32'hFFFF_FFFE;
    force u_reg.starve_cnt = 32'hFFFF_FFFE;
    #1;
    release u_reg.stall_cnt;
    release u_reg.starve_cnt;
    for (int c = 0; c < 3; c++) step();
    cmp("stats_stall_sat", bus0.o_stall_cnt, STAT_CNT_MAX);
    tb_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    cmp("stats_starve_sat", bus0.o_starve_cnt, STAT_CNT_MAX);
    tb_flush = 1'b1;
    step();
    tb_flush = 1'b0;
    cmp("stats_flush_stall", bus0.o_stall_cnt, 32'd0);
    cmp("stats_flush_starve", bus0.o_starve_cnt, 32'd0);
`endif

    // Fall-through instance.
    ft = 1;
    tb_ready = 1'b0;
    src.push_back(32'hA5);
    step();
    cmp("ft_pop", s_re, 1'b1);
    cmp("ft_valid_before", s_v, 1'b0);
    step();
    cmp("ft_valid", s_v, 1'b1);
    cmp("ft_data", s_d, 32'hA5);
    cmp("ft_level", s_l, 1);
    cmp("ft_no_pop_empty", s_re, 1'b0);
    tb_ready = 1'b1;
    step();
    rand_phase(300, 75);
    rand_phase(200, 25);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
